// File: rtl/rom_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : rom_stream_reader
// Brief    : Turns a (base, len) request into a valid/ready word stream from a
//            1-cycle-latency, active-low-enable ROM through a 2-entry FIFO.
//            Optional macro ROM_STREAM_WRAP_EN: address pointer wraps at ROM_DEPTH.
// Revision : 1.0 - initial release
// ============================================================================
module rom_stream_reader #(
    parameter int ROM_DEPTH = 1024,
    parameter int NUM_DATA  = 1,
    parameter int BIT_WIDTH = 16,
    localparam int AW = $clog2(ROM_DEPTH),
    localparam int DW = NUM_DATA * BIT_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          rom_cen,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_q,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [AW+1:0] c_depth_ext = (AW+2)'(ROM_DEPTH);
`ifdef ROM_STREAM_WRAP_EN
    localparam logic [AW-1:0] c_last_addr = AW'(ROM_DEPTH - 1);
`else
    logic [AW+1:0] w_req_end;
`endif

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d, addr_q, addr_d, w_ptr_next;
    logic [AW:0]   remaining_q, remaining_d;
    logic          inflight_q, inflight_d;
    logic          err_q, err_d;
    logic [DW-1:0] mem_q [2];
    logic [DW-1:0] mem_d [2];
    logic          wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
    logic [1:0]    count_q, count_d;
    logic          w_pop, w_push, w_issue, w_illegal;
    logic [2:0]    w_occupancy;

    always_comb begin
`ifdef ROM_STREAM_WRAP_EN
        w_illegal  = ({2'b00, base_addr} >= c_depth_ext);
        // Explicit compare keeps non-power-of-two depths wrapping correctly.
        w_ptr_next = (ptr_q == c_last_addr) ? '0 : ptr_q + AW'(1);
`else
        w_req_end  = {2'b00, base_addr} + {1'b0, len};
        w_illegal  = ({2'b00, base_addr} >= c_depth_ext) || (w_req_end > c_depth_ext);
        w_ptr_next = ptr_q + AW'(1);
`endif
        w_pop       = (count_q != 2'd0) && out_ready;
        w_push      = inflight_q;
        // Words owed to the FIFO after this cycle's pop; a new read needs a free slot.
        w_occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, w_pop};
        w_issue     = (state_q == S_FETCH) && (remaining_q != '0) && (w_occupancy <= 3'd1);

        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        inflight_d  = w_issue;
        err_d       = 1'b0;
        mem_d[0]    = mem_q[0];
        mem_d[1]    = mem_q[1];
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        count_d     = count_q;

        if (w_issue) begin
            ptr_d       = w_ptr_next;
            remaining_d = remaining_q - (AW+1)'(1);
            addr_d      = ptr_q;
        end
        if (w_push) begin
            mem_d[wr_idx_q] = rom_q;
            wr_idx_d        = ~wr_idx_q;
        end
        if (w_pop) begin
            rd_idx_d = ~rd_idx_q;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_d = S_DONE;
                    end else if (w_illegal) begin
                        err_d = 1'b1;
                    end else begin
                        state_d     = S_FETCH;
                        ptr_d       = base_addr;
                        remaining_d = len;
                    end
                end
            end
            S_FETCH: begin
                if (w_issue && (remaining_q == (AW+1)'(1))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((count_d == 2'd0) && !inflight_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            addr_q      <= '0;
            inflight_q  <= 1'b0;
            err_q       <= 1'b0;
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
            wr_idx_q    <= 1'b0;
            rd_idx_q    <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            inflight_q  <= inflight_d;
            err_q       <= err_d;
            mem_q[0]    <= mem_d[0];
            mem_q[1]    <= mem_d[1];
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            count_q     <= count_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign rom_cen   = ~w_issue;
    assign rom_addr  = w_issue ? ptr_q : addr_q;
    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[rd_idx_q];

endmodule
`default_nettype wire

// File: tb/tb_rom_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_stream_reader
// Brief    : Self-checking bench: ROM model, event monitor, per-scenario tests.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_stream_reader;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n, start, out_ready;
    logic [9:0]  base_addr, rom_addr;
    logic [10:0] len;
    logic        busy, done, err, rom_cen, out_valid;
    logic [15:0] rom_q, out_data;

    always #5 clk = ~clk;

    rom_stream_reader #(.ROM_DEPTH(DEPTH), .NUM_DATA(1), .BIT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .err(err), .rom_cen(rom_cen), .rom_addr(rom_addr),
        .rom_q(rom_q), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    // ROM: one-cycle latency, drives X when not enabled
    logic [15:0] rom_mem [DEPTH];
    always @(posedge clk) rom_q <= rom_cen ? 16'hxxxx : rom_mem[rom_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled mid-cycle
    int          issue_addr_q[$], issue_cyc_q[$], hs_cyc_q[$];
    int          done_cyc_q[$], err_cyc_q[$], fall_cyc_q[$];
    logic [15:0] hs_data_q[$];
    int          n_iss = 0, n_hs = 0, occ_bad = 0, x_bad = 0, valid_cnt = 0, busy_cnt = 0;
    bit          prev_busy = 0;

    always @(negedge clk) begin : mon
        bit pop;
        if (!rst_n) begin
            n_hs      = n_iss;
            prev_busy = 0;
        end else begin
            pop = out_valid && out_ready;
            if (!rom_cen) begin
                if (n_iss - n_hs - (pop ? 1 : 0) + 1 > 2) occ_bad++;
                issue_addr_q.push_back(int'(rom_addr));
                issue_cyc_q.push_back(cyc);
                n_iss++;
            end
            if (out_valid) begin
                valid_cnt++;
                if ($isunknown(out_data)) x_bad++;
            end
            if (pop) begin
                hs_data_q.push_back(out_data);
                hs_cyc_q.push_back(cyc);
                n_hs++;
            end
            if (done) done_cyc_q.push_back(cyc);
            if (err)  err_cyc_q.push_back(cyc);
            if (busy) begin
                busy_cnt++;
                prev_busy = 1;
            end else if (prev_busy) begin
                fall_cyc_q.push_back(cyc);
                prev_busy = 0;
            end
        end
    end

    int n_checks = 0, n_fail = 0;
    int c0, s_iss, s_hs, s_done, s_err, s_fall, s_occ, s_x, s_valid, s_busy;
    logic [15:0] exp_q[$];
    int          exp_addr_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit rdy(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (k % 4 == 0) || (k % 4 == 3);
        return bit'($urandom_range(0, 1));
    endfunction

    // Reference stream: consecutive addresses, wrapping modulo the ROM depth
    function automatic void build_exp(input int base, input int ln);
        exp_q.delete();
        exp_addr_q.delete();
        for (int i = 0; i < ln; i++) begin
            exp_addr_q.push_back((base + i) % DEPTH);
            exp_q.push_back(rom_mem[(base + i) % DEPTH]);
        end
    endfunction

    function automatic void snapshot();
        s_iss = issue_addr_q.size(); s_hs = hs_data_q.size(); s_done = done_cyc_q.size();
        s_err = err_cyc_q.size();    s_fall = fall_cyc_q.size(); s_occ = occ_bad;
        s_x = x_bad;                 s_valid = valid_cnt;      s_busy = busy_cnt;
    endfunction

    task automatic run_stream(input int base, input int ln, input int mode,
                              input int restart_k, output int timeout);
        int k = 0;
        snapshot();
        c0 = cyc;
        timeout = 0;
        start = 1'b1; base_addr = base[9:0]; len = ln[10:0]; out_ready = rdy(mode, 0);
        forever begin
            step();
            k++;
            if (k == restart_k) begin
                start = 1'b1; base_addr = 10'd200; len = 11'd3;
            end else begin
                start = 1'b0;
            end
            out_ready = rdy(mode, k);
            if (done_cyc_q.size() > s_done || err_cyc_q.size() > s_err) begin
                step();
                break;
            end
            if (k > 4000) begin
                timeout = 1;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({busy, done, err, rom_cen, out_valid} !== 5'b00010) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 00010", {busy, done, err, rom_cen, out_valid});
        end
        n_checks++;
        if (rom_addr !== 10'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", rom_addr); end
        n_checks++;
        if (out_data !== 16'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", out_data); end
    endtask

    task automatic test_basic();
        int to;
        run_stream(0, 4, 0, 0, to);
        build_exp(0, 4);
        n_checks++;
        if (to !== 0) begin n_fail++; $display("FAIL basic_timeout: got %0d want 0", to); end
        n_checks++;
        if (issue_addr_q.size() - s_iss !== 4) begin
            n_fail++; $display("FAIL basic_issue_count: got %0d want 4", issue_addr_q.size() - s_iss);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (issue_addr_q[s_iss+i] !== exp_addr_q[i] || issue_cyc_q[s_iss+i] !== c0 + 1 + i) begin
                    n_fail++;
                    $display("FAIL basic_issue[%0d]: got addr %0d cyc %0d want addr %0d cyc %0d", i,
                             issue_addr_q[s_iss+i], issue_cyc_q[s_iss+i] - c0, exp_addr_q[i], 1 + i);
                end
            end
        end
        n_checks++;
        if (hs_data_q.size() - s_hs !== 4) begin
            n_fail++; $display("FAIL basic_word_count: got %0d want 4", hs_data_q.size() - s_hs);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (hs_data_q[s_hs+i] !== exp_q[i] || hs_cyc_q[s_hs+i] !== c0 + 3 + i) begin
                    n_fail++;
                    $display("FAIL basic_word[%0d]: got %h at cyc %0d want %h at cyc %0d", i,
                             hs_data_q[s_hs+i], hs_cyc_q[s_hs+i] - c0, exp_q[i], 3 + i);
                end
            end
        end
        n_checks++;
        if (done_cyc_q.size() - s_done !== 1 || done_cyc_q[s_done] !== c0 + 7) begin
            n_fail++; $display("FAIL basic_done: got %0d pulses first at cyc %0d want 1 at cyc 7",
                               done_cyc_q.size() - s_done, done_cyc_q[s_done] - c0);
        end
        n_checks++;
        if (fall_cyc_q.size() - s_fall !== 1 || fall_cyc_q[s_fall] !== c0 + 8) begin
            n_fail++; $display("FAIL basic_busy_fall: got cyc %0d want cyc 8", fall_cyc_q[s_fall] - c0);
        end
    endtask

    task automatic test_backpressure();
        int to;
        run_stream(10, 8, 1, 0, to);
        build_exp(10, 8);
        n_checks++;
        if (to !== 0 || done_cyc_q.size() - s_done !== 1) begin
            n_fail++; $display("FAIL bp_done: got timeout %0d pulses %0d want 0 and 1", to, done_cyc_q.size() - s_done);
        end
        n_checks++;
        if (issue_addr_q.size() - s_iss !== 8 || hs_data_q.size() - s_hs !== 8) begin
            n_fail++; $display("FAIL bp_count: got %0d issues %0d words want 8 and 8",
                               issue_addr_q.size() - s_iss, hs_data_q.size() - s_hs);
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (issue_addr_q[s_iss+i] !== exp_addr_q[i] || hs_data_q[s_hs+i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL bp_word[%0d]: got addr %0d data %h want addr %0d data %h", i,
                                       issue_addr_q[s_iss+i], hs_data_q[s_hs+i], exp_addr_q[i], exp_q[i]);
                end
            end
        end
        n_checks++;
        if (occ_bad !== s_occ) begin n_fail++; $display("FAIL bp_occupancy: got %0d overissues want 0", occ_bad - s_occ); end
        n_checks++;
        if (x_bad !== s_x) begin n_fail++; $display("FAIL bp_x_data: got %0d X words want 0", x_bad - s_x); end
    endtask

    task automatic test_len_zero();
        int to;
        run_stream(5, 0, 0, 0, to);
        n_checks++;
        if (to !== 0 || done_cyc_q.size() - s_done !== 1 || done_cyc_q[s_done] !== c0 + 1) begin
            n_fail++; $display("FAIL len0_done: got cyc %0d want cyc 1", done_cyc_q[s_done] - c0);
        end
        n_checks++;
        if (issue_addr_q.size() !== s_iss || valid_cnt !== s_valid || err_cyc_q.size() !== s_err) begin
            n_fail++; $display("FAIL len0_quiet: got %0d issues %0d valid %0d err want 0 0 0",
                               issue_addr_q.size() - s_iss, valid_cnt - s_valid, err_cyc_q.size() - s_err);
        end
    endtask

    task automatic test_range();
        int to;
        run_stream(1020, 8, 0, 0, to);
        build_exp(1020, 8);
`ifdef ROM_STREAM_WRAP_EN
        n_checks++;
        if (to !== 0 || issue_addr_q.size() - s_iss !== 8 || hs_data_q.size() - s_hs !== 8) begin
            n_fail++; $display("FAIL wrap_count: got %0d issues %0d words want 8 and 8",
                               issue_addr_q.size() - s_iss, hs_data_q.size() - s_hs);
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (issue_addr_q[s_iss+i] !== exp_addr_q[i] || hs_data_q[s_hs+i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL wrap_word[%0d]: got addr %0d data %h want addr %0d data %h", i,
                                       issue_addr_q[s_iss+i], hs_data_q[s_hs+i], exp_addr_q[i], exp_q[i]);
                end
            end
        end
`else
        n_checks++;
        if (to !== 0 || err_cyc_q.size() - s_err !== 1 || err_cyc_q[s_err] !== c0 + 1) begin
            n_fail++; $display("FAIL range_err: got %0d pulses first at cyc %0d want 1 at cyc 1",
                               err_cyc_q.size() - s_err, err_cyc_q[s_err] - c0);
        end
        n_checks++;
        if (issue_addr_q.size() !== s_iss || busy_cnt !== s_busy || done_cyc_q.size() !== s_done) begin
            n_fail++; $display("FAIL range_quiet: got %0d issues %0d busy %0d done want 0 0 0",
                               issue_addr_q.size() - s_iss, busy_cnt - s_busy, done_cyc_q.size() - s_done);
        end
`endif
    endtask

    task automatic test_restart();
        int to;
        run_stream(100, 6, 2, 3, to);
        build_exp(100, 6);
        n_checks++;
        if (to !== 0 || done_cyc_q.size() - s_done !== 1 || err_cyc_q.size() !== s_err) begin
            n_fail++; $display("FAIL restart_end: got timeout %0d done %0d err %0d want 0 1 0",
                               to, done_cyc_q.size() - s_done, err_cyc_q.size() - s_err);
        end
        n_checks++;
        if (hs_data_q.size() - s_hs !== 6 || issue_addr_q.size() - s_iss !== 6) begin
            n_fail++; $display("FAIL restart_count: got %0d words want 6", hs_data_q.size() - s_hs);
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (hs_data_q[s_hs+i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL restart_word[%0d]: got %h want %h", i, hs_data_q[s_hs+i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int to;
        start = 1'b1; base_addr = 10'd300; len = 11'd10; out_ready = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, err, rom_cen, out_valid} !== 5'b00010 || rom_addr !== 10'd0 || out_data !== 16'd0) begin
            n_fail++; $display("FAIL midreset_outputs: got ctrl %b addr %0d data %h want 00010 0 0",
                               {busy, done, err, rom_cen, out_valid}, rom_addr, out_data);
        end
        step();
        rst_n = 1'b1;
        step();
        run_stream(50, 5, 1, 0, to);
        build_exp(50, 5);
        n_checks++;
        if (to !== 0 || hs_data_q.size() - s_hs !== 5) begin
            n_fail++; $display("FAIL midreset_count: got %0d words want 5", hs_data_q.size() - s_hs);
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (hs_data_q[s_hs+i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL midreset_word[%0d]: got %h want %h", i, hs_data_q[s_hs+i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        int to, base, ln, bad;
        for (int t = 0; t < 8; t++) begin
            base = int'($urandom_range(0, DEPTH - 1));
`ifdef ROM_STREAM_WRAP_EN
            ln = int'($urandom_range(1, 40));
`else
            ln = int'($urandom_range(1, (DEPTH - base < 40) ? DEPTH - base : 40));
`endif
            run_stream(base, ln, 2, 0, to);
            build_exp(base, ln);
            bad = 0;
            if (hs_data_q.size() - s_hs != ln) bad = 1;
            else for (int i = 0; i < ln; i++) if (hs_data_q[s_hs+i] !== exp_q[i]) bad = 1;
            n_checks++;
            if (to !== 0 || bad !== 0 || occ_bad !== s_occ || x_bad !== s_x) begin
                n_fail++; $display("FAIL random[%0d] base %0d len %0d: got %0d words timeout %0d overissue %0d X %0d want %0d words and no errors",
                                   t, base, ln, hs_data_q.size() - s_hs, to, occ_bad - s_occ, x_bad - s_x, ln);
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; base_addr = '0; len = '0;
        for (int i = 0; i < DEPTH; i++) rom_mem[i] = 16'($urandom);
        repeat (2) step();
        test_reset();
        rst_n = 1'b1;
        step();
        test_basic();
        test_backpressure();
        test_len_zero();
        test_range();
        test_restart();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
